// File: rtl/aes_enc_pkg.sv
// Shared definitions for the AES-128 encryptor: FSM states, round constants
// and GF(2^8) helpers used by the S-box and the MixColumns datapath.
package aes_enc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Rcon is indexed 1..NUM_ROUNDS; anything else yields zero.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] rnd);
        logic [3:0] idx;
        idx = rnd - 4'd1;
        if (rnd >= 4'd1 && rnd <= NUM_ROUNDS) begin
            return RCON[idx];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// followed by the FIPS-197 affine transform.
module aes_sbox
    import aes_enc_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] pow_sq;
    logic [7:0] inv;

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
    always_comb begin
        pow_sq = in_byte;
        inv    = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            pow_sq = gf_mul(pow_sq, pow_sq);
            inv    = gf_mul(inv, pow_sq);
        end
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Optional AES_LAST_KEY output (final round key) when AES_ENC_LAST_KEY_OUT_EN is defined.
module aes_encrypt
    import aes_enc_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    input  logic         AES_START,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_PLAIN,
    output logic         AES_DONE,
    output logic [127:0] AES_MSG_ENC
`ifdef AES_ENC_LAST_KEY_OUT_EN
    ,
    output logic [127:0] AES_LAST_KEY
`endif
);

    aes_state_e   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] enc_q, enc_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;
`ifdef AES_ENC_LAST_KEY_OUT_EN
    logic [127:0] last_key_q, last_key_d;
`endif

    logic [127:0] sub_bytes;
    logic [127:0] shifted;
    logic [127:0] next_key;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  key_temp;

    for (genvar i = 0; i < 16; i++) begin : g_state_sbox
        aes_sbox u_sbox (
            .in_byte  (state_q[127-8*i -: 8]),
            .out_byte (sub_bytes[127-8*i -: 8])
        );
    end

    assign rot_word = {key_q[23:0], key_q[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_word[31-8*j -: 8]),
            .out_byte (sub_word[31-8*j -: 8])
        );
    end

    // Byte k = row + 4*col; row r rotates left by r columns.
    always_comb begin
        shifted = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                shifted[127-8*(r+4*c) -: 8] = sub_bytes[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    end

    always_comb begin
        key_temp                = sub_word ^ {rcon_lookup(round_q), 24'h000000};
        next_key[127:96]        = key_q[127:96] ^ key_temp;
        next_key[95:64]         = key_q[95:64]  ^ next_key[127:96];
        next_key[63:32]         = key_q[63:32]  ^ next_key[95:64];
        next_key[31:0]          = key_q[31:0]   ^ next_key[63:32];
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        enc_d   = enc_q;
        round_d = round_q;
`ifdef AES_ENC_LAST_KEY_OUT_EN
        last_key_d = last_key_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (AES_START) begin
                    state_d = AES_MSG_PLAIN ^ AES_KEY;
                    key_d   = AES_KEY;
                    round_d = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                key_d   = next_key;
                state_d = mix_columns(shifted) ^ next_key;
                round_d = round_q + 4'd1;
                if (round_q == NUM_ROUNDS - 4'd1) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                key_d   = next_key;
                state_d = shifted ^ next_key;
                enc_d   = shifted ^ next_key;
`ifdef AES_ENC_LAST_KEY_OUT_EN
                last_key_d = next_key;
`endif
                fsm_d   = DONE;
            end
            DONE: begin
                if (!AES_START) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        done_d = (fsm_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            enc_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
            last_key_q <= '0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            enc_q   <= enc_d;
            round_q <= round_d;
            done_q  <= done_d;
`ifdef AES_ENC_LAST_KEY_OUT_EN
            last_key_q <= last_key_d;
`endif
        end
    end

    assign AES_DONE    = done_q;
    assign AES_MSG_ENC = enc_q;
`ifdef AES_ENC_LAST_KEY_OUT_EN
    assign AES_LAST_KEY = last_key_q;
`endif

endmodule

// File: tb/tb_aes_encrypt.sv
// Scoreboard bench for aes_encrypt: byte-array FIPS-197 reference model,
// known-answer vectors and randomized operations.
module tb_aes_encrypt;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         AES_START;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_PLAIN;
    logic         AES_DONE;
    logic [127:0] AES_MSG_ENC;
`ifdef AES_ENC_LAST_KEY_OUT_EN
    logic [127:0] AES_LAST_KEY;
`endif

    always #5 CLK = ~CLK;

    aes_encrypt dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .AES_START     (AES_START),
        .AES_KEY       (AES_KEY),
        .AES_MSG_PLAIN (AES_MSG_PLAIN),
        .AES_DONE      (AES_DONE),
        .AES_MSG_ENC   (AES_MSG_ENC)
`ifdef AES_ENC_LAST_KEY_OUT_EN
        ,
        .AES_LAST_KEY  (AES_LAST_KEY)
`endif
    );

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] LK2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        logic [127:0] enc;
        logic [127:0] lk;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           n_pass = 0;
    int           n_total = 0;
    int           done_rises = 0;
    logic         prev_done = 1'b0;
    logic [127:0] last_enc;
    logic [7:0]   sbox_t[256];
    logic [7:0]   alog[256];
    int           lg[256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return (b[7]) ? ((b << 1) ^ 8'h1b) : (b << 1);
    endfunction

    // S-box from log/antilog tables over generator 3, then the affine map.
    task automatic build_sbox();
        logic [7:0] e;
        logic [7:0] v;
        e = 8'h01;
        for (int i = 0; i < 255; i++) begin
            alog[i] = e;
            lg[e]   = i;
            e       = e ^ xt(e);
        end
        for (int x = 0; x < 256; x++) begin
            v = (x == 0) ? 8'h00 : alog[(255 - lg[x]) % 255];
            sbox_t[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                          ^ {v[3:0], v[7:4]} ^ 8'h63;
        end
    endtask

    function automatic void aes_model(input logic [127:0] k, input logic [127:0] p,
                                      output logic [127:0] enc, output logic [127:0] lk);
        logic [31:0] w[44];
        logic [7:0]  s[16];
        logic [7:0]  t[16];
        logic [7:0]  rc;
        logic [31:0] tmp;
        logic [7:0]  a0, a1, a2, a3;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                      ^ {rc, 24'h000000};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j < 16; j++) begin
            tmp  = w[j/4];
            s[j] = p[127-8*j -: 8] ^ tmp[31-8*(j%4) -: 8];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int j = 0; j < 16; j++) t[j] = sbox_t[s[j]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r+4*c] = t[r + 4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
                    s[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int j = 0; j < 16; j++) begin
                tmp  = w[4*rnd + j/4];
                s[j] = s[j] ^ tmp[31-8*(j%4) -: 8];
            end
        end
        for (int j = 0; j < 16; j++) enc[127-8*j -: 8] = s[j];
        lk = {w[40], w[41], w[42], w[43]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    // Monitor: every new AES_DONE interval retires one scoreboard entry.
    always @(negedge CLK) begin
        if (AES_DONE === 1'b1 && prev_done !== 1'b1) begin
            done_rises++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got AES_DONE=1, expected no pending operation");
            end else begin
                mon_e = exp_q.pop_front();
                chk("ciphertext", AES_MSG_ENC, mon_e.enc);
`ifdef AES_ENC_LAST_KEY_OUT_EN
                chk("last_key", AES_LAST_KEY, mon_e.lk);
`endif
            end
        end
        prev_done = AES_DONE;
    end

    // mode: 0 plain, 1 inputs forced to all-ones after accept, 2 random input/start churn.
    task automatic do_op(input logic [127:0] k, input logic [127:0] p, input int mode,
                         input int hold_extra, input bit kat,
                         input logic [127:0] kat_enc, input logic [127:0] kat_lk);
        exp_t         e;
        logic [127:0] m_enc, m_lk;
        int           rises0;
        AES_START = 1'b0;
        @(posedge CLK); #1;
        aes_model(k, p, m_enc, m_lk);
        e.enc = m_enc;
        e.lk  = m_lk;
        if (kat) begin
            e.enc = kat_enc;
            if (kat_lk !== '0) e.lk = kat_lk;
        end
        exp_q.push_back(e);
        AES_KEY       = k;
        AES_MSG_PLAIN = p;
        AES_START     = 1'b1;
        rises0        = done_rises;
        for (int i = 1; i <= 11; i++) begin
            @(posedge CLK); #1;
            if (i == 1 && hold_extra == 0) AES_START = 1'b0;
            if (i == 2 && mode == 1) begin
                AES_KEY       = '1;
                AES_MSG_PLAIN = '1;
            end
            if (mode == 2 && i >= 2 && i <= 9) begin
                AES_START     = 1'($urandom_range(0, 1));
                AES_KEY       = rand128();
                AES_MSG_PLAIN = rand128();
            end
            if (mode == 2 && i == 10) AES_START = (hold_extra > 0);
            if (i == 10) begin
                chk("done_before_final", {127'd0, AES_DONE}, 128'd0);
                chk("enc_held", AES_MSG_ENC, last_enc);
            end
        end
        chk("done_latency", {127'd0, AES_DONE}, 128'd1);
        last_enc = e.enc;
        if (hold_extra > 0) begin
            repeat (hold_extra) begin
                @(posedge CLK); #1;
            end
            chk("done_held", {127'd0, AES_DONE}, 128'd1);
            chk("single_done", 128'(done_rises - rises0), 128'd1);
        end
        AES_START = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1);
    end

    initial begin
        int rises0;
        RESET         = 1'b1;
        AES_START     = 1'b0;
        AES_KEY       = '0;
        AES_MSG_PLAIN = '0;
        last_enc      = '0;
        build_sbox();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_done", {127'd0, AES_DONE}, 128'd0);
        chk("reset_enc", AES_MSG_ENC, 128'd0);

        // Reset must win over a start on the same edge.
        AES_START = 1'b1;
        AES_KEY   = K1;
        AES_MSG_PLAIN = P1;
        @(posedge CLK); #1;
        RESET     = 1'b0;
        AES_START = 1'b0;
        rises0    = done_rises;
        repeat (14) @(posedge CLK);
        #1;
        chk("reset_priority", 128'(done_rises - rises0), 128'd0);

        do_op(K1, P1, 0, 0, 1'b1, C1, '0);
        do_op(K2, P2, 0, 0, 1'b1, C2, LK2);
        do_op(K1, P1, 1, 0, 1'b1, C1, '0);

        // Abort an operation with reset at its 6th edge.
        AES_START = 1'b0;
        @(posedge CLK); #1;
        AES_KEY = K2; AES_MSG_PLAIN = P2; AES_START = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge CLK); #1;
            AES_START = 1'b0;
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk("mid_reset_done", {127'd0, AES_DONE}, 128'd0);
        chk("mid_reset_enc", AES_MSG_ENC, 128'd0);
        last_enc = '0;
        rises0 = done_rises;
        repeat (12) @(posedge CLK);
        #1;
        chk("aborted_no_done", 128'(done_rises - rises0), 128'd0);

        do_op(K2, P2, 0, 0, 1'b1, C2, LK2);
        do_op(K1, P1, 0, 19, 1'b1, C1, '0);
        do_op(K2, P2, 0, 0, 1'b1, C2, LK2);
        do_op(K1, P1, 0, 0, 1'b1, C1, '0);
        do_op(K2, P2, 0, 0, 1'b1, C2, LK2);

        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #1;
            do_op(rand128(), rand128(), ($urandom_range(0, 1) == 0) ? 0 : 2,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                  1'b0, '0, '0);
        end

        repeat (4) @(posedge CLK);
        #1;
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
